// File: rtl/fpu_operand_sequencer.sv
// Issue-and-capture stage around a combinational FPU adder/subtractor: walks the
// operand ROMs, drives registered operands, and buffers each result behind valid/ready.
module fpu_operand_sequencer #(
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [1:0]            i_op_mode,
   input  logic [ADDR_WIDTH-1:0] i_last_addr,
   output logic [ADDR_WIDTH-1:0] o_rom_addr,
   input  logic [31:0]           i_rom_a,
   input  logic [31:0]           i_rom_b,
   output logic                  o_add_sub,
   output logic [31:0]           o_32_a,
   output logic [31:0]           o_32_b,
   input  logic [31:0]           i_32_s,
   input  logic                  i_ov_flag,
   input  logic                  i_un_flag,
   output logic                  o_res_valid,
   input  logic                  i_res_ready,
   output logic [31:0]           o_res_data,
   output logic                  o_res_ov,
   output logic                  o_res_un,
   output logic [ADDR_WIDTH-1:0] o_res_addr,
   output logic                  o_res_sub,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [CNT_WIDTH-1:0]  o_ov_cnt,
   output logic [CNT_WIDTH-1:0]  o_un_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_LOAD, S_EXEC, S_HOLD} state_t;

   localparam logic [1:0] MODE_SUB  = 2'b01;
   localparam logic [1:0] MODE_BOTH = 2'b10;

   state_t                state_q, state_d;
   logic [1:0]            mode_q;
   logic [ADDR_WIDTH-1:0] last_q;
   logic                  accept;
   logic                  both_second;
   logic                  run_end;

   assign accept      = (state_q == S_HOLD) && o_res_valid && i_res_ready;
   assign both_second = (mode_q == MODE_BOTH) && !o_add_sub;
   assign run_end     = (o_rom_addr == last_q);
   assign o_busy      = (state_q != S_IDLE);

   // NOTE: state and datapath registers use non-blocking assignments so every
   // process sees the pre-edge values regardless of evaluation order.
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: next state gets its default first, so no path through this block
   // leaves state_d unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (i_start) state_d = S_READ;
         S_READ: state_d = S_LOAD;
         S_LOAD: state_d = S_EXEC;
         S_EXEC: state_d = S_HOLD;
         S_HOLD: begin
            if (accept) begin
               if (both_second)  state_d = S_EXEC;
               else if (run_end) state_d = S_IDLE;
               else              state_d = S_READ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mode_q      <= '0;
         last_q      <= '0;
         o_rom_addr  <= '0;
         o_add_sub   <= 1'b0;
         o_32_a      <= '0;
         o_32_b      <= '0;
         o_res_valid <= 1'b0;
         o_res_data  <= '0;
         o_res_ov    <= 1'b0;
         o_res_un    <= 1'b0;
         o_res_addr  <= '0;
         o_res_sub   <= 1'b0;
         o_done      <= 1'b0;
         o_ov_cnt    <= '0;
         o_un_cnt    <= '0;
      end else begin
         o_done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  mode_q     <= i_op_mode;
                  last_q     <= i_last_addr;
                  o_rom_addr <= '0;
                  o_ov_cnt   <= '0;
                  o_un_cnt   <= '0;
                  o_add_sub  <= (i_op_mode == MODE_SUB);
               end
            end
            S_LOAD: begin
               o_32_a <= i_rom_a;
               o_32_b <= i_rom_b;
            end
            S_EXEC: begin
               o_res_valid <= 1'b1;
               o_res_data  <= i_32_s;
               o_res_ov    <= i_ov_flag;
               o_res_un    <= i_un_flag;
               o_res_addr  <= o_rom_addr;
               o_res_sub   <= o_add_sub;
            end
            S_HOLD: begin
               if (accept) begin
                  o_res_valid <= 1'b0;
                  if (o_res_ov && (o_ov_cnt != '1)) o_ov_cnt <= o_ov_cnt + CNT_WIDTH'(1);
                  if (o_res_un && (o_un_cnt != '1)) o_un_cnt <= o_un_cnt + CNT_WIDTH'(1);
                  // BOTH mode reuses the loaded operands for the subtract pass.
                  if (both_second) begin
                     o_add_sub <= 1'b1;
                  end else if (run_end) begin
                     o_done <= 1'b1;
                  end else begin
                     o_rom_addr <= o_rom_addr + ADDR_WIDTH'(1);
                     o_add_sub  <= (mode_q == MODE_SUB);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_operand_sequencer.sv
// Randomized bench for fpu_operand_sequencer: ROM and FPU stand-ins plus a
// run-level expected-result queue built from the address range and mode.
module tb_fpu_operand_sequencer;

   typedef struct packed {
      logic [4:0]  addr;
      logic        sub;
      logic        ov;
      logic        un;
      logic [31:0] data;
   } res_t;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic [1:0]  i_op_mode = 2'b00;
   logic [4:0]  i_last_addr = 5'd0;
   logic [4:0]  o_rom_addr;
   logic [31:0] i_rom_a, i_rom_b;
   logic        o_add_sub;
   logic [31:0] o_32_a, o_32_b;
   logic [31:0] i_32_s;
   logic        i_ov_flag, i_un_flag;
   logic        o_res_valid;
   logic        i_res_ready = 1'b0;
   logic [31:0] o_res_data;
   logic        o_res_ov, o_res_un;
   logic [4:0]  o_res_addr;
   logic        o_res_sub;
   logic        o_busy, o_done;
   logic [15:0] o_ov_cnt, o_un_cnt;

   logic [31:0] rom_a [32];
   logic [31:0] rom_b [32];
   res_t        exp_q [$];
   logic [31:0] got_q [$];
   int          cyc = 0;
   int          done_lat;
   int          n_checks = 0;
   int          n_fail = 0;

   fpu_operand_sequencer dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op_mode(i_op_mode),
      .i_last_addr(i_last_addr), .o_rom_addr(o_rom_addr), .i_rom_a(i_rom_a),
      .i_rom_b(i_rom_b), .o_add_sub(o_add_sub), .o_32_a(o_32_a), .o_32_b(o_32_b),
      .i_32_s(i_32_s), .i_ov_flag(i_ov_flag), .i_un_flag(i_un_flag),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
      .o_res_ov(o_res_ov), .o_res_un(o_res_un), .o_res_addr(o_res_addr),
      .o_res_sub(o_res_sub), .o_busy(o_busy), .o_done(o_done),
      .o_ov_cnt(o_ov_cnt), .o_un_cnt(o_un_cnt)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Synchronous-read operand ROMs, one-cycle latency.
   always @(posedge i_clk) begin
      i_rom_a <= rom_a[o_rom_addr];
      i_rom_b <= rom_b[o_rom_addr];
   end

   function automatic real sp_to_real(input logic [31:0] b);
      logic [63:0] d;
      if (b[30:23] == 8'd0) return 0.0;
      d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   // Single-precision add/sub, round-to-nearest-even; returns {ov, un, sum}.
   function automatic logic [33:0] fpu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub);
      real         r;
      logic [63:0] d;
      int          e;
      logic [24:0] m;
      logic        inc;
      r = sub ? sp_to_real(a) - sp_to_real(b) : sp_to_real(a) + sp_to_real(b);
      if (r == 0.0) return 34'd0;
      d   = $realtobits(r);
      e   = int'(d[62:52]) - 896;
      inc = d[28] && ((|d[27:0]) || d[29]);
      m   = {2'b01, d[51:29]} + 25'(inc);
      if (m[24]) e++;
      if (e >= 255) return {1'b1, 1'b0, d[63], 8'hFF, 23'd0};
      if (e <= 0)   return {1'b0, 1'b1, d[63], 31'd0};
      return {2'b00, d[63], 8'(e), m[22:0]};
   endfunction

   assign {i_ov_flag, i_un_flag, i_32_s} = fpu_ref(o_32_a, o_32_b, o_add_sub);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ops"}, {o_32_a, o_32_b}, 64'd0);
      check({tag, "_res"}, {o_res_data, o_res_addr, o_res_valid, o_res_ov, o_res_un, o_res_sub}, 64'd0);
      check({tag, "_ctl"}, {o_rom_addr, o_add_sub, o_busy, o_done, o_ov_cnt, o_un_cnt}, 64'd0);
   endtask

   task automatic fill_rom_random();
      for (int i = 0; i < 32; i++) begin
         rom_a[i] = $urandom;
         rom_b[i] = $urandom;
      end
   endtask

   // One complete run from i_start to o_done, scoreboarded against exp_q.
   task automatic run(input logic [1:0] mode, input logic [4:0] last, input int ready_pct,
                      input bit stall_first, input bit poke);
      res_t        r;
      int          t0, exp_valid_at, last_hs, stall, exp_ov, exp_un;
      bit          waiting, finished, hs_prev, prev_valid;
      logic [44:0] snap_res;
      logic [63:0] snap_ops;
      exp_q.delete();
      got_q.delete();
      for (int a = 0; a <= int'(last); a++) begin
         for (int k = 0; k < ((mode == 2'b10) ? 2 : 1); k++) begin
            r.addr = 5'(a);
            r.sub  = (mode == 2'b01) || (k == 1);
            {r.ov, r.un, r.data} = fpu_ref(rom_a[a], rom_b[a], r.sub);
            exp_q.push_back(r);
         end
      end
      @(negedge i_clk);
      i_op_mode   = mode;
      i_last_addr = last;
      i_start     = 1'b1;
      i_res_ready = 1'b0;
      @(negedge i_clk);
      i_start      = 1'b0;
      t0           = cyc;
      exp_valid_at = t0 + 3;
      last_hs      = -10;
      stall        = stall_first ? 7 : 0;
      exp_ov       = 0;
      exp_un       = 0;
      waiting      = 1'b1;
      finished     = 1'b0;
      hs_prev      = 1'b0;
      prev_valid   = 1'b0;
      snap_res     = '0;
      snap_ops     = '0;
      for (int n = 0; n < 4000 && !finished; n++) begin
         if (poke) i_start = (n == 37);
         i_op_mode   = 2'($urandom);
         i_last_addr = 5'($urandom);
         if (hs_prev) begin
            check("valid_drop", o_res_valid, 1'b0);
         end else if (o_res_valid && prev_valid) begin
            check("hold_res", {o_res_data, o_res_addr, o_res_sub, o_res_ov, o_res_un, o_rom_addr}, snap_res);
            check("hold_ops", {o_32_a, o_32_b}, snap_ops);
         end
         if (o_res_valid && waiting) begin
            check("valid_latency", cyc, exp_valid_at);
            check("busy_run", o_busy, 1'b1);
            waiting = 1'b0;
         end
         if (o_done) begin
            done_lat = cyc - t0;
            check("done_timing", cyc, last_hs);
            check("busy_at_done", o_busy, 1'b0);
            check("results_left", exp_q.size(), 0);
            check("ov_cnt", o_ov_cnt, exp_ov);
            check("un_cnt", o_un_cnt, exp_un);
            finished = 1'b1;
         end else begin
            if (o_res_valid && stall > 0) begin
               i_res_ready = 1'b0;
               stall--;
            end else begin
               i_res_ready = ($urandom_range(99) < ready_pct);
            end
            hs_prev = o_res_valid && i_res_ready;
            if (hs_prev) begin
               got_q.push_back(o_res_data);
               if (exp_q.size() == 0) begin
                  check("extra_result", 1'b1, 1'b0);
               end else begin
                  r = exp_q.pop_front();
                  check("res_data", o_res_data, r.data);
                  check("res_addr", o_res_addr, r.addr);
                  check("res_sub_ov_un", {o_res_sub, o_res_ov, o_res_un}, {r.sub, r.ov, r.un});
                  exp_ov += int'(r.ov);
                  exp_un += int'(r.un);
                  exp_valid_at = cyc + (((mode == 2'b10) && !r.sub) ? 2 : 4);
                  waiting      = 1'b1;
                  last_hs      = cyc + 1;
               end
            end
            prev_valid = o_res_valid;
            snap_res   = {o_res_data, o_res_addr, o_res_sub, o_res_ov, o_res_un, o_rom_addr};
            snap_ops   = {o_32_a, o_32_b};
            @(negedge i_clk);
         end
      end
      if (!finished) check("run_timeout", finished, 1'b1);
      i_start     = 1'b0;
      i_res_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         check("idle_after_done", {o_done, o_busy, o_res_valid}, 3'b000);
      end
   endtask

   initial begin
      bit hit;
      fill_rom_random();
      rom_a[0] = 32'h40b00000;
      rom_b[0] = 32'h400ccccd;
      rom_a[1] = 32'h7f7fffff;
      rom_b[1] = 32'h7f7fffff;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      check_reset("reset");

      run(2'b00, 5'd0, 100, 1'b0, 1'b0);
      check("tp_add_count", got_q.size(), 1);
      if (got_q.size() > 0) check("tp_add_data", got_q[0], 32'h40f66666);
      check("tp_done_lat", done_lat, 4);

      run(2'b10, 5'd0, 100, 1'b0, 1'b0);
      check("tp_both_count", got_q.size(), 2);
      if (got_q.size() > 1) begin
         check("tp_both_add", got_q[0], 32'h40f66666);
         check("tp_both_sub", got_q[1], 32'h40533333);
      end

      run(2'b00, 5'd1, 100, 1'b0, 1'b0);
      check("tp_ov_cnt", o_ov_cnt, 16'd1);
      check("tp_un_cnt", o_un_cnt, 16'd0);

      run(2'b00, 5'd1, 100, 1'b1, 1'b0);
      run(2'b01, 5'd5, 60, 1'b0, 1'b0);
      run(2'b11, 5'd3, 70, 1'b0, 1'b0);

      fill_rom_random();
      run(2'b00, 5'd31, 100, 1'b0, 1'b1);
      check("tp_full_count", got_q.size(), 32);
      run(2'b10, 5'd31, 50, 1'b0, 1'b1);
      run(2'b01, 5'($urandom), 80, 1'b0, 1'b0);

      // Reset while a result is pending in HOLD at address 3.
      @(negedge i_clk);
      i_op_mode   = 2'b00;
      i_last_addr = 5'd7;
      i_start     = 1'b1;
      i_res_ready = 1'b1;
      hit = 1'b0;
      for (int n = 0; n < 200 && !hit; n++) begin
         @(negedge i_clk);
         i_start = 1'b0;
         if (o_res_valid && o_res_addr == 5'd3) begin
            i_res_ready = 1'b0;
            hit = 1'b1;
         end
      end
      check("reach_addr3", hit, 1'b1);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      check_reset("rst_hold");
      run(2'b00, 5'd4, 100, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_operand_sequencer.md
# fpu_operand_sequencer

Upstream issue-and-capture stage for the combinational `FPU_unit` adder/subtractor.
- Upstream side: walks an operand address range in a pair of synchronous-read operand ROMs (A and B, one-cycle read latency). Drives registered operands and the add/sub select into the FPU.
- Downstream side: captures each FPU result with its overflow/underflow flags into a valid/ready output register, and keeps running flag counters.

## Interface
Parameters:
- ADDR_WIDTH, 5, operand ROM address width.
- CNT_WIDTH, 16, width of the overflow/underflow event counters.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, synchronous and active-high. ROMs needing active-low reset get `~i_rst` at integration.
- i_start  in  1  start a run. Sampled only in IDLE.
- i_op_mode  in  2  operation mode: 00 = ADD, 01 = SUB, 10 = BOTH (ADD then SUB per pair), 11 = treated as ADD. Latched at start.
- i_last_addr  in  ADDR_WIDTH  last address of the run, inclusive. Latched at start.
- o_rom_addr  out  ADDR_WIDTH  address to both operand ROMs.
- i_rom_a / i_rom_b  in  32  ROM read data. Valid the cycle after the address is presented.
- o_add_sub  out  1  to FPU: 0 = add, 1 = subtract.
- o_32_a / o_32_b  out  32  registered FPU operands.
- i_32_s  in  32  FPU sum/difference (combinational from o_32_a, o_32_b, o_add_sub).
- i_ov_flag / i_un_flag  in  1  FPU overflow/underflow flags.
- o_res_valid  out  1  result register holds an unconsumed result.
- i_res_ready  in  1  consumer accepts the result.
- o_res_data  out  32  captured result.
- o_res_ov / o_res_un  out  1  captured flags.
- o_res_addr  out  ADDR_WIDTH  operand address of the result.
- o_res_sub  out  1  result is a subtraction.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the run completes.
- o_ov_cnt / o_un_cnt  out  CNT_WIDTH  saturating counts of accepted results with ov/un set.

## Operation
States: IDLE, READ, LOAD, EXEC, HOLD.

Per-state behaviour:
- IDLE: when `i_start` = 1, latch mode and last address, set the address to 0, clear both counters, set `o_add_sub` = (mode == 01), go to READ.
- READ: `o_rom_addr` is stable; the ROMs sample it at the end of the cycle. Go to LOAD.
- LOAD: register `i_rom_a` / `i_rom_b` into `o_32_a` / `o_32_b`. Go to EXEC.
- EXEC: FPU inputs are stable. At the end of the cycle, capture `i_32_s`, `i_ov_flag`, `i_un_flag`, the address and `o_add_sub` into the result register. Set `o_res_valid`. Go to HOLD.
- HOLD: stay until `o_res_valid` && `i_res_ready`. On that handshake:
  - clear valid;
  - increment counters for set flags, saturating at all-ones;
  - then the first matching rule applies:
    - mode BOTH and current op is add: set `o_add_sub` = 1, go to EXEC. Operands are reused, no ROM re-read.
    - address == last address: pulse `o_done`, go to IDLE.
    - otherwise: address + 1, restore `o_add_sub` to the mode default, go to READ.

Rules and boundaries:
- Result register, operands and address hold stable while in HOLD.
- `i_start` outside IDLE is ignored.
- `i_op_mode` / `i_last_addr` changes mid-run have no effect.
- `i_last_addr` = all-ones: the run covers all 2^ADDR_WIDTH entries. The address never wraps to 0 within a run.
- `i_last_addr` = 0: exactly one pair, or two results in BOTH mode.
- Flags and data pass through unmodified; no arithmetic on results.
- `i_rst` at any cycle, including mid-run or in HOLD: next edge forces IDLE and all reset values. The pending result is discarded.

## Timing
- Reset values: state IDLE; `o_rom_addr`, `o_32_a`, `o_32_b`, `o_res_data`, `o_res_addr`, `o_ov_cnt`, `o_un_cnt` = 0; `o_add_sub`, `o_res_valid`, `o_res_ov`, `o_res_un`, `o_res_sub`, `o_busy`, `o_done` = 0.
- `i_start` sampled at edge t: READ during cycle t+1, LOAD t+2, EXEC t+3. `o_res_valid` = 1 from t+4.
- Throughput with `i_res_ready` tied high: one result per 4 cycles (READ, LOAD, EXEC, HOLD). The BOTH-mode second result follows 2 cycles after the first handshake.
- `o_done` is high for exactly the cycle after the final handshake edge; `o_busy` is 0 in that same cycle.
- `o_res_*` are registered outputs; no combinational path from `i_res_ready` to any output.

## Test plan
- ROM[0] = 40b00000 / 400ccccd, mode ADD, last = 0, ready high: one result `o_res_data` = 40f66666 (7.7), flags 0, `o_res_addr` 0. `o_done` pulses 5 cycles after start.
- Same pair, mode BOTH: results 40f66666 (sub = 0), then 40533333 (3.3, sub = 1). Exactly one ROM read.
- ROM[1] = 7f7fffff / 7f7fffff, mode ADD, last = 1: second result has ov = 1. Final `o_ov_cnt` = 1, `o_un_cnt` = 0.
- Backpressure: hold `i_res_ready` low 7 cycles in HOLD. `o_res_*` stay constant, no address advance. Acceptance occurs on the first ready-high edge.
- Last = 31, ready high, random ROM: 32 results with addresses 0..31 in order; `o_done` once, no address-0 re-issue. A second `i_start` mid-run is ignored.
- Assert `i_rst` while in HOLD at address 3: next cycle all outputs equal their reset values. A new `i_start` restarts from address 0 with cleared counters.
